// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: holds the RV32I core in reset, streams a counted image into
// instruction memory word by word, verifies an XOR checksum, then releases the core.
module boot_loader_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boot_req,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  count_lo_r;
    logic [15:0] count_r;
    logic [1:0]  byte_idx_r;
    logic [15:0] word_cnt_r;
    logic [23:0] asm_r;
    logic [7:0]  chk_acc_r;
    logic        xfer_s;
    logic        start_s;
    logic        last_word_s;
    logic [15:0] hdr_count_s;
    logic [31:0] word_s;

    function automatic logic [7:0] xsum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Handshake, header and word-assembly helpers derived from current state.
    always_comb begin
        xfer_s      = rx_valid & rx_ready;
        start_s     = boot_req & ((state_r == S_IDLE) | (state_r == S_RUN) | (state_r == S_ERR));
        hdr_count_s = {rx_data, count_lo_r};
        last_word_s = (word_cnt_r == (count_r - 16'd1));
        word_s      = {rx_data, asm_r};
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_RUN, S_ERR: begin
                if (boot_req) state_nxt_s = S_HDR0;
                else          state_nxt_s = state_r;
            end
            S_HDR0: begin
                if (xfer_s) state_nxt_s = S_HDR1;
                else        state_nxt_s = S_HDR0;
            end
            S_HDR1: begin
                if (xfer_s) begin
                    if ((hdr_count_s == 16'd0) || (hdr_count_s > DEPTH_W)) state_nxt_s = S_ERR;
                    else                                                   state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_HDR1;
                end
            end
            S_DATA: begin
                if (xfer_s && (byte_idx_r == 2'd3) && last_word_s) state_nxt_s = S_CHK;
                else                                               state_nxt_s = S_DATA;
            end
            S_CHK: begin
                if (xfer_s) begin
                    if (rx_data == chk_acc_r) state_nxt_s = S_RUN;
                    else                      state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_CHK;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and status flags, registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            rx_ready  <= (state_nxt_s == S_HDR0) | (state_nxt_s == S_HDR1) |
                         (state_nxt_s == S_DATA) | (state_nxt_s == S_CHK);
            busy      <= (state_nxt_s == S_HDR0) | (state_nxt_s == S_HDR1) |
                         (state_nxt_s == S_DATA) | (state_nxt_s == S_CHK);
            done      <= (state_nxt_s == S_RUN);
            error     <= (state_nxt_s == S_ERR);
            cpu_reset <= (state_nxt_s != S_RUN);
        end
    end

    // Byte capture, word assembly, checksum accumulation and the memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_lo_r   <= 8'd0;
            count_r      <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_cnt_r   <= 16'd0;
            asm_r        <= 24'd0;
            chk_acc_r    <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (start_s) begin
                byte_idx_r   <= 2'd0;
                word_cnt_r   <= 16'd0;
                words_loaded <= 16'd0;
                chk_acc_r    <= 8'd0;
            end else if (xfer_s) begin
                case (state_r)
                    S_HDR0: count_lo_r <= rx_data;
                    S_HDR1: count_r    <= hdr_count_s;
                    S_DATA: begin
                        chk_acc_r  <= xsum_next(chk_acc_r, rx_data);
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= word_cnt_r[AW-1:0];
                            imem_wdata   <= word_s;
                            words_loaded <= words_loaded + 16'd1;
                            word_cnt_r   <= word_cnt_r + 16'd1;
                        end else begin
                            asm_r <= {rx_data, asm_r[23:8]};
                        end
                    end
                    default: begin
                        count_lo_r <= count_lo_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: cycle table for a full good load plus
// sequences for error headers, max-size image, back-pressure, async reset and restarts.
module tb_boot_loader_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          boot_req = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    always #5 clk = ~clk;

    boot_loader_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .boot_req(boot_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          cr;
        logic          bz;
        logic          dn;
        logic          er;
        logic [15:0]   wl;
    } obs_t;

    typedef struct {
        logic       br;
        logic       v;
        logic [7:0] d;
        obs_t       exp;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    logic [AW+31:0] wlog[$];

    always @(negedge clk) if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});

    function automatic obs_t mk(logic rdy, logic we, logic [AW-1:0] a, logic [31:0] wd,
                                logic cr, logic bz, logic dn, logic er, logic [15:0] wl);
        obs_t o;
        o.rdy = rdy; o.we = we; o.addr = a; o.wdata = wd;
        o.cr = cr; o.bz = bz; o.dn = dn; o.er = er; o.wl = wl;
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error, words_loaded);
    endfunction

    task automatic check_obs(input string nm, input obs_t e);
        obs_t g;
        g = cur();
        n_vec++;
        if (g !== e) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic check_writes(input string nm, input logic [AW+31:0] exp[$]);
        bit ok;
        ok = (wlog.size() == exp.size());
        if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %0d writes (first %h) expected %0d writes (first %h)", nm,
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : '0,
                     exp.size(), (exp.size() > 0) ? exp[0] : '0);
        end
    endtask

    // Offers bytes with rx_valid asserted vpct% of cycles; optional boot_req pulse at byte br_at.
    task automatic send(input logic [7:0] bytes[$], input int vpct, input int br_at);
        int  i;
        int  guard;
        logic v;
        logic acc;
        i = 0;
        guard = 0;
        while (i < bytes.size()) begin
            v = ($urandom_range(99) < vpct);
            boot_req = (i == br_at);
            rx_valid = v;
            rx_data  = v ? bytes[i] : 8'($urandom);
            acc = v & rx_ready;
            @(negedge clk);
            if (acc) i++;
            guard++;
            if (guard > 20000) begin
                n_vec++;
                n_miss++;
                $display("FAIL send_timeout: got %0d bytes accepted expected %0d", i, bytes.size());
                break;
            end
        end
        boot_req = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic boot();
        boot_req = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    vec_t           tab[14];
    logic [7:0]     gs[$];
    logic [7:0]     bs[$];
    logic [7:0]     big[$];
    logic [AW+31:0] gw[$];
    logic [AW+31:0] bw[$];
    logic [AW+31:0] none[$];
    logic [31:0]    w;
    logic [7:0]     xs;

    initial begin
        gs = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        bs = gs;
        bs[10] = 8'h91;
        gw = '{{9'd0, 32'h00000013}, {9'd1, 32'h00100093}};

        tab[0]  = '{1'b1, 1'b0, 8'h00, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[1]  = '{1'b0, 1'b1, 8'h02, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[2]  = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[3]  = '{1'b0, 1'b1, 8'h13, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[4]  = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[5]  = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
        tab[6]  = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b1, 9'd0, 32'h00000013, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1)};
        tab[7]  = '{1'b0, 1'b1, 8'h93, mk(1'b1, 1'b0, 9'd0, 32'h00000013, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1)};
        tab[8]  = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b0, 9'd0, 32'h00000013, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1)};
        tab[9]  = '{1'b0, 1'b1, 8'h10, mk(1'b1, 1'b0, 9'd0, 32'h00000013, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1)};
        tab[10] = '{1'b0, 1'b1, 8'h00, mk(1'b1, 1'b1, 9'd1, 32'h00100093, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2)};
        tab[11] = '{1'b0, 1'b1, 8'h90, mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2)};
        tab[12] = '{1'b0, 1'b1, 8'h55, mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2)};
        tab[13] = '{1'b1, 1'b0, 8'h00, mk(1'b1, 1'b0, 9'd1, 32'h00100093, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};

        repeat (2) @(negedge clk);
        check_obs("reset_state", mk(1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        reset = 1'b1;
        @(negedge clk);

        // Cycle-by-cycle good load, idle byte in RUN, then restart from RUN.
        for (int i = 0; i < 14; i++) begin
            boot_req = tab[i].br;
            rx_valid = tab[i].v;
            rx_data  = tab[i].d;
            @(negedge clk);
            check_obs($sformatf("tab%0d", i), tab[i].exp);
        end
        boot_req = 1'b0;
        rx_valid = 1'b0;
        check_writes("tab_writes", gw);

        // Second image after restart, with ~50% valid back-pressure.
        wlog.delete();
        send(gs, 50, -1);
        check_obs("stress_done", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
        check_writes("stress_writes", gw);

        // Bad checksum.
        boot();
        wlog.delete();
        send(bs, 100, -1);
        check_obs("bad_chk", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2));
        check_writes("bad_chk_writes", gw);

        // Zero count.
        boot();
        wlog.delete();
        send('{8'h00, 8'h00}, 100, -1);
        check_obs("count_zero", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0));
        check_writes("count_zero_writes", none);

        // Count DEPTH+1.
        boot();
        wlog.delete();
        send('{8'h01, 8'h02}, 100, -1);
        check_obs("count_over", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0));
        check_writes("count_over_writes", none);

        // Count exactly DEPTH.
        big.push_back(8'h00);
        big.push_back(8'h02);
        xs = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i) ^ 8'hA5, 8'(i >> 8), 8'h3C, 8'(i)};
            for (int b = 0; b < 4; b++) begin
                big.push_back(w[8*b +: 8]);
                xs = xs ^ w[8*b +: 8];
            end
            bw.push_back({9'(i), w});
        end
        big.push_back(xs);
        boot();
        wlog.delete();
        send(big, 100, -1);
        w = {8'hFF ^ 8'hA5, 8'h01, 8'h3C, 8'hFF};
        check_obs("count_max", mk(1'b0, 1'b0, 9'd511, w, 1'b0, 1'b0, 1'b1, 1'b0, 16'd512));
        check_writes("count_max_writes", bw);

        // boot_req during DATA is ignored.
        boot();
        wlog.delete();
        send(gs, 100, 5);
        check_obs("br_in_data", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
        check_writes("br_in_data_writes", gw);

        // Async reset between edges after 5 data bytes, then a clean reload.
        boot();
        send('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93}, 100, -1);
        #2 reset = 1'b0;
        #1 check_obs("async_reset", mk(1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        boot();
        wlog.delete();
        send(gs, 100, -1);
        check_obs("post_reset_load", mk(1'b0, 1'b0, 9'd1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
        check_writes("post_reset_writes", gw);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
